// File: rtl/class_pkg.sv
// Shared definitions for the class merge arbiter: defaults, class-bit
// position and the last-grant state encoding.
package class_pkg;
  localparam int DATA_SIZE_DEF = 10;
  localparam int WEIGHT_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT0 = 2'd2
  } state_t;

  function automatic int class_bit(input int data_size);
    return data_size - 1;
  endfunction
endpackage

// File: rtl/class_arb_grant.sv
// Combinational pop decision: class 1 wins unless it has already taken
// WEIGHT grants in a row while class 0 is waiting.
module class_arb_grant #(
  parameter int WEIGHT = 4
) (
  input  logic       reset,
  input  logic       pause,
  input  logic       fifo0_empty,
  input  logic       fifo1_empty,
  input  logic [3:0] streak,
  output logic       pop0,
  output logic       pop1
);
  logic w_ok;
  logic w_c1_allowed;

  assign w_ok         = reset && !pause;
  assign w_c1_allowed = (streak < 4'(WEIGHT)) || fifo0_empty;
  assign pop1         = w_ok && !fifo1_empty && w_c1_allowed;
  assign pop0         = w_ok && !fifo0_empty && !pop1;
endmodule

// File: rtl/class_merge_arb.sv
// Merges the class-0 and class-1 FWFT FIFOs into one registered stream,
// flagging words whose class bit disagrees with their source FIFO.
module class_merge_arb
  import class_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int WEIGHT    = WEIGHT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] fifo0_data,
  input  logic                 fifo0_empty,
  input  logic [DATA_SIZE-1:0] fifo1_data,
  input  logic                 fifo1_empty,
  input  logic                 pause,
  output logic                 fifo0_pop,
  output logic                 fifo1_pop,
  output logic [DATA_SIZE-1:0] out,
  output logic                 valid_out,
  output logic                 error
);
  localparam int CB = class_bit(DATA_SIZE);

  state_t               r_state;
  logic [3:0]           r_streak;
  logic [DATA_SIZE-1:0] r_out;
  logic                 r_err;
  logic                 w_pop0;
  logic                 w_pop1;

  class_arb_grant #(.WEIGHT(WEIGHT)) u_grant (
    .reset       (reset),
    .pause       (pause),
    .fifo0_empty (fifo0_empty),
    .fifo1_empty (fifo1_empty),
    .streak      (r_streak),
    .pop0        (w_pop0),
    .pop1        (w_pop1)
  );

  // Streak survives idle/pause cycles; only a class-0 grant or reset clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_streak <= '0;
      r_out    <= '0;
      r_err    <= 1'b0;
    end else if (w_pop1) begin
      r_state <= GNT1;
      r_out   <= fifo1_data;
      if (r_streak < 4'(WEIGHT)) r_streak <= r_streak + 4'd1;
      if (!fifo1_data[CB]) r_err <= 1'b1;
    end else if (w_pop0) begin
      r_state  <= GNT0;
      r_out    <= fifo0_data;
      r_streak <= '0;
      if (fifo0_data[CB]) r_err <= 1'b1;
    end else begin
      r_state <= IDLE;
    end
  end

  assign fifo0_pop = w_pop0;
  assign fifo1_pop = w_pop1;
  assign out       = r_out;
  assign valid_out = (r_state != IDLE);
  assign error     = r_err;
endmodule

// File: tb/tb_class_merge_arb.sv
// Scoreboard bench: queue-based FIFO/arbitration model predicts pops and
// output words; a separate monitor checks every word the DUT presents.
module tb_class_merge_arb;
  localparam int DW = 10;
  localparam int WT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pause = 1'b0;
  logic          f0_empty, f1_empty;
  logic [DW-1:0] f0_data, f1_data;
  logic          f0_pop, f1_pop;
  logic [DW-1:0] out;
  logic          valid_out, error;

  class_merge_arb #(.DATA_SIZE(DW), .WEIGHT(WT)) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo0_data  (f0_data),
    .fifo0_empty (f0_empty),
    .fifo1_data  (f1_data),
    .fifo1_empty (f1_empty),
    .pause       (pause),
    .fifo0_pop   (f0_pop),
    .fifo1_pop   (f1_pop),
    .out         (out),
    .valid_out   (valid_out),
    .error       (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] w;
    logic          err;
  } exp_t;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            m_run1 = 0;     // consecutive class-1 grants so far
  logic          m_err = 1'b0;
  logic          prev_rst = 1'b0;
  logic          prev_pop = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_heads();
    f0_empty = (q0.size() == 0);
    f1_empty = (q1.size() == 0);
    f0_data  = f0_empty ? '0 : q0[0];
    f1_data  = f1_empty ? '0 : q1[0];
  endtask

  // One clock cycle: apply inputs, predict and check the grant, advance the model.
  task automatic step(input logic rst, input logic pz);
    logic          e0, e1;
    logic [DW-1:0] w;
    reset = rst;
    pause = pz;
    drive_heads();
    @(negedge clk);
    chk("valid_out", {31'd0, valid_out}, {31'd0, prev_pop});
    if (!prev_rst) begin
      chk("rst_out", {22'd0, out}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
    end
    e0 = 1'b0;
    e1 = 1'b0;
    if (rst && !pz) begin
      if (q1.size() > 0 && (m_run1 < WT || q0.size() == 0)) e1 = 1'b1;
      else if (q0.size() > 0) e0 = 1'b1;
    end
    chk("fifo1_pop", {31'd0, f1_pop}, {31'd0, e1});
    chk("fifo0_pop", {31'd0, f0_pop}, {31'd0, e0});
    if (e1) begin
      w = q1.pop_front();
      if (w[DW-1] == 1'b0) m_err = 1'b1;
      sb.push_back('{w, m_err});
      m_run1 = (m_run1 + 1 > WT) ? WT : m_run1 + 1;
    end else if (e0) begin
      w = q0.pop_front();
      if (w[DW-1] == 1'b1) m_err = 1'b1;
      sb.push_back('{w, m_err});
      m_run1 = 0;
    end
    if (!rst) begin
      m_run1 = 0;
      m_err  = 1'b0;
    end
    prev_rst = rst;
    prev_pop = e0 | e1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q0.size() > 0 || q1.size() > 0); i++) step(1'b1, 1'b0);
    if (q0.size() > 0 || q1.size() > 0) chk("drain_timeout", 32'd1, 32'd0);
    step(1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", {22'd0, out}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("out", {22'd0, out}, {22'd0, e.w});
        chk("error", {31'd0, error}, {31'd0, e.err});
      end
    end
  end

  initial begin
    logic [DW-1:0] w;
    drive_heads();
    // Reset held with both FIFOs non-empty
    for (int i = 0; i < 3; i++) begin
      q0.push_back(10'h155);
      q1.push_back(10'h2AA);
    end
    repeat (3) step(1'b0, 1'b0);
    drain();
    // Three class-1 words, class 0 empty
    repeat (3) q1.push_back(10'h3FF);
    drain();
    // Weighted pattern from a fresh streak
    step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      q0.push_back(10'h155);
      q1.push_back(10'h2AA);
    end
    repeat (4) step(1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b1);
    drain();
    // Class-0 head with class bit 1: sticky error, cleared by reset
    q0.push_back(10'h3FF);
    q1.push_back(10'h2AA);
    repeat (4) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    // Reset mid-stream with streak at 3
    for (int i = 0; i < 8; i++) begin
      q0.push_back(10'h155);
      q1.push_back(10'h2AA);
    end
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    drain();
    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        w = DW'($urandom);
        w[DW-1] = ($urandom_range(0, 15) == 0);
        q0.push_back(w);
      end
      if ($urandom_range(0, 1) == 0) begin
        w = DW'($urandom);
        w[DW-1] = ($urandom_range(0, 15) != 0);
        q1.push_back(w);
      end
      step($urandom_range(0, 79) != 0, $urandom_range(0, 5) == 0);
    end
    drain();
    step(1'b1, 1'b0);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
